// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the lapido hazard controller.
// Holds the FSM state encoding used by hazard_controller.
package hazard_controller_pkg;

  localparam int HZ_STATE_W = 2;

  localparam logic [HZ_STATE_W-1:0] HZ_RUN      = 2'd0;
  localparam logic [HZ_STATE_W-1:0] HZ_MEM_WAIT = 2'd1;
  localparam logic [HZ_STATE_W-1:0] HZ_RECOVER  = 2'd2;

  typedef enum logic [HZ_STATE_W-1:0] {
    ST_RUN      = HZ_RUN,
    ST_MEM_WAIT = HZ_MEM_WAIT,
    ST_RECOVER  = HZ_RECOVER
  } hz_state_e;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter for performance statistics.
// Ports: clk, rst (async active-low), inc, count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stage enables, flushes, ID bubble.
// In: ID/EX/MEM hazard info; Out: enables, flushes, timeout, counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_jump,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_wr_addr,
  input  logic              mem_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write_enable,
  output logic              if_id_write_enable,
  output logic              id_ex_write_enable,
  output logic              ex_mem_write_enable,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              stall_pipeline,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  logic rs_hit, rt_hit, load_use;
  logic ev_busy, ev_br, ev_lu, ev_jmp;

  assign rs_hit = id_uses_rs && (id_rs == ex_wr_addr);
  assign rt_hit = id_uses_rt && (id_rt == ex_wr_addr);
  assign load_use = ex_is_load && (ex_wr_addr != '0)
                    && (rs_hit || rt_hit);

  // One-hot event select; earlier events mask later ones.
  assign ev_busy = mem_busy;
  assign ev_br   = !mem_busy && mem_branch_taken;
  assign ev_lu   = !mem_busy && !mem_branch_taken && load_use;
  assign ev_jmp  = !mem_busy && !mem_branch_taken
                   && !load_use && id_is_jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Timeout fires on the busy cycle that would make the
  // wait streak reach MEM_WAIT_MAX.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          state_d   = ST_RECOVER;
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // MEM_WAIT shares the RUN decode: with mem_busy high it is
  // the freeze case, with mem_busy low it is a normal RUN cycle.
  always_comb begin
    pc_write_enable     = 1'b1;
    if_id_write_enable  = 1'b1;
    id_ex_write_enable  = 1'b1;
    ex_mem_write_enable = 1'b1;
    flush_if_id         = 1'b0;
    flush_id_ex         = 1'b0;
    flush_ex_mem        = 1'b0;
    stall_pipeline      = 1'b0;
    if (!rst) begin
      pc_write_enable     = 1'b0;
      if_id_write_enable  = 1'b0;
      id_ex_write_enable  = 1'b0;
      ex_mem_write_enable = 1'b0;
      flush_if_id         = 1'b1;
      flush_id_ex         = 1'b1;
      flush_ex_mem        = 1'b1;
      stall_pipeline      = 1'b1;
    end else if (state_q == ST_RECOVER) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else begin
      unique case (1'b1)
        ev_busy: begin
          pc_write_enable     = 1'b0;
          if_id_write_enable  = 1'b0;
          id_ex_write_enable  = 1'b0;
          ex_mem_write_enable = 1'b0;
        end
        ev_br: begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end
        ev_lu: begin
          pc_write_enable    = 1'b0;
          if_id_write_enable = 1'b0;
          flush_id_ex        = 1'b1;
          stall_pipeline     = 1'b1;
        end
        ev_jmp: begin
          flush_if_id = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_write_enable),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if_id || flush_id_ex || flush_ex_mem),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
// Drives inputs 1ns after posedge, checks before next edge.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_wr_addr;
  logic        id_uses_rs, id_uses_rt, id_is_jump;
  logic        ex_is_load, mem_branch_taken, mem_busy;
  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        fl_ifid, fl_idex, fl_exmem;
  logic        stall_pipeline, mem_timeout;
  logic [15:0] stall_cycles, flush_events;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_rs               (id_rs),
    .id_rt               (id_rt),
    .id_uses_rs          (id_uses_rs),
    .id_uses_rt          (id_uses_rt),
    .id_is_jump          (id_is_jump),
    .ex_is_load          (ex_is_load),
    .ex_wr_addr          (ex_wr_addr),
    .mem_branch_taken    (mem_branch_taken),
    .mem_busy            (mem_busy),
    .pc_write_enable     (pc_we),
    .if_id_write_enable  (ifid_we),
    .id_ex_write_enable  (idex_we),
    .ex_mem_write_enable (exmem_we),
    .flush_if_id         (fl_ifid),
    .flush_id_ex         (fl_idex),
    .flush_ex_mem        (fl_exmem),
    .stall_pipeline      (stall_pipeline),
    .mem_timeout         (mem_timeout),
    .stall_cycles        (stall_cycles),
    .flush_events        (flush_events)
  );

  wire [3:0] en = {pc_we, ifid_we, idex_we, exmem_we};
  wire [2:0] fl = {fl_ifid, fl_idex, fl_exmem};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_wr_addr = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_jump = 0;
    ex_is_load = 0; mem_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_wr_addr = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1;
  endtask

  initial begin
    idle();
    step(); step();
    chk("rst_en", en, 4'h0);
    chk("rst_fl", fl, 3'h7);
    chk("rst_stall", stall_pipeline, 1);
    chk("rst_scnt", stall_cycles, 0);
    chk("rst_fcnt", flush_events, 0);
    chk("rst_to", mem_timeout, 0);
    rst = 1'b1;
    #1;
    chk("idle_en", en, 4'hF);
    chk("idle_fl", fl, 3'h0);
    chk("idle_stall", stall_pipeline, 0);

    set_lu();
    #1;
    chk("lu_en", en, 4'b0011);
    chk("lu_fl", fl, 3'b010);
    chk("lu_stall", stall_pipeline, 1);
    step();
    idle();
    #1;
    chk("lu_scnt", stall_cycles, 1);
    chk("lu_fcnt", flush_events, 1);
    chk("lu_after_en", en, 4'hF);

    ex_is_load = 1; ex_wr_addr = 0; id_uses_rs = 1;
    #1;
    chk("r0_en", en, 4'hF);
    chk("r0_stall", stall_pipeline, 0);
    ex_wr_addr = 5'd5; id_rs = 5'd5; id_uses_rs = 0;
    id_rt = 5'd5; id_uses_rt = 0;
    #1;
    chk("nouse_en", en, 4'hF);
    id_uses_rt = 1;
    #1;
    chk("rt_en", en, 4'b0011);
    chk("rt_fl", fl, 3'b010);
    step();
    idle();
    #1;
    chk("rt_scnt", stall_cycles, 2);

    id_is_jump = 1;
    #1;
    chk("jmp_fl", fl, 3'b100);
    chk("jmp_en", en, 4'hF);
    step();
    idle();

    mem_branch_taken = 1; id_is_jump = 1; set_lu();
    #1;
    chk("prio_fl", fl, 3'b111);
    chk("prio_en", en, 4'hF);
    chk("prio_stall", stall_pipeline, 0);
    step();
    idle();
    #1;
    chk("prio_fcnt", flush_events, 4);
    chk("prio_scnt", stall_cycles, 2);

    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw4_en", en, 4'h0);
      chk("mw4_fl", fl, 3'h0);
      step();
    end
    mem_busy = 0; mem_branch_taken = 1;
    #1;
    chk("mw4_exit_en", en, 4'hF);
    chk("mw4_exit_fl", fl, 3'h7);
    step();
    idle();
    #1;
    chk("mw4_scnt", stall_cycles, 6);
    chk("mw4_fcnt", flush_events, 5);
    chk("mw4_to", mem_timeout, 0);

    mem_busy = 1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (i == 16) begin
        chk("rec_en", en, 4'hF);
        chk("rec_fl", fl, 3'h7);
      end else begin
        chk("mw20_en", en, 4'h0);
        chk("mw20_fl", fl, 3'h0);
      end
      step();
      chk("mw20_to", mem_timeout, (i >= 15) ? 1 : 0);
    end
    mem_busy = 0;
    #1;
    chk("mw20_exit_en", en, 4'hF);
    step();
    chk("mw20_scnt", stall_cycles, 25);
    chk("mw20_fcnt", flush_events, 6);
    chk("to_sticky", mem_timeout, 1);

    set_lu();
    repeat (65539) step();
    chk("sat_en", en, 4'b0011);
    chk("sat_scnt", stall_cycles, 16'hFFFF);
    chk("sat_fcnt", flush_events, 16'hFFFF);
    idle();

    mem_busy = 1;
    step(); step();
    chk("pre_rst_en", en, 4'h0);
    rst = 1'b0;
    #1;
    chk("arst_scnt", stall_cycles, 0);
    chk("arst_fcnt", flush_events, 0);
    chk("arst_to", mem_timeout, 0);
    chk("arst_en", en, 4'h0);
    chk("arst_fl", fl, 3'h7);
    chk("arst_stall", stall_pipeline, 1);
    mem_busy = 0;
    step();
    rst = 1'b1;
    #1;
    chk("rel_en", en, 4'hF);
    chk("rel_fl", fl, 3'h0);
    step();
    chk("rel_scnt", stall_cycles, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage lapido core. Sits beside the ID stage and watches the ID, EX and MEM stages. Each cycle it decides whether to advance, freeze, or flush the IF/ID, ID/EX and EX/MEM pipeline registers. It drives the ID stage `stall_pipeline` input, which turns the decoded instruction into a bubble. It also keeps saturating performance counters for stalls and flushes.

## Interface
- `ADDR_W`, 5, register address width (matches `GRP_ADDR_WIDTH`).
- `MEM_WAIT_MAX`, 15, maximum consecutive data-memory wait cycles before timeout.
- `CNT_W`, 16, width of the performance counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  ADDR_W  source register addresses of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1  the ID instruction actually reads rs / rt.
- `id_is_jump`  in  1  unconditional jump resolved in ID.
- `ex_is_load`  in  1  instruction in EX is a load.
- `ex_wr_addr`  in  ADDR_W  destination register of the EX instruction, after the reg_dst mux.
- `mem_branch_taken`  in  1  PC-relative branch or flag jump resolved taken in MEM.
- `mem_busy`  in  1  data memory not ready this cycle.
- `pc_write_enable`, `if_id_write_enable`, `id_ex_write_enable`, `ex_mem_write_enable`  out  1  stage-register advance enables.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1  load a bubble (all-zero controls) into the register.
- `stall_pipeline`  out  1  to ID control unit; forces zero control signals.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`, `flush_events`  out  CNT_W  saturating performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, RECOVER.
- Event conditions, evaluated in RUN and in priority order:
  - **mem_busy**: mem_busy=1.
  - **branch**: mem_branch_taken=1.
  - **load_use**: ex_is_load=1, ex_wr_addr≠0, and either (id_uses_rs and id_rs==ex_wr_addr) or (id_uses_rt and id_rt==ex_wr_addr).
  - **jump**: id_is_jump=1.
- Default outputs: all enables 1, all flushes 0, stall_pipeline 0.
- **mem_busy**: all enables 0, no flushes. Next state MEM_WAIT and wait counter set to 1. A pending branch is held because EX/MEM is frozen.
- **branch**: flush_if_id, flush_id_ex and flush_ex_mem all 1; enables stay 1.
- **load_use**: pc_write_enable=0, if_id_write_enable=0, flush_id_ex=1, stall_pipeline=1. The bubble covers exactly one cycle; afterwards the load is in MEM.
- **jump**: flush_if_id=1 only.
- MEM_WAIT:
  - Outputs are the same as the mem_busy case.
  - While mem_busy=1, the counter increments.
  - On mem_busy=0, go to RUN. That cycle uses RUN output logic.
  - When the counter reaches MEM_WAIT_MAX with mem_busy still 1, set mem_timeout and go to RECOVER.
- RECOVER: one cycle with all three flushes 1 and all enables 1, then RUN.
- mem_timeout clears only on reset.
- `stall_cycles` increments in every cycle where pc_write_enable=0.
- `flush_events` increments once per cycle in which any flush is 1.
- Both counters hold at 2^CNT_W−1 (saturate, never wrap).

## Timing
- All outputs except the counters and mem_timeout are combinational from state and the current inputs. Zero-cycle latency, because the stage registers sample them on the same edge.
- Counters and mem_timeout are registered and update on the edge following the counted cycle.
- While rst=0:
  - state is RUN, wait counter is 0, counters and mem_timeout are 0;
  - all enables are forced to 0, all flushes to 1, stall_pipeline to 1.
- Reset asserted mid-MEM_WAIT aborts immediately (asynchronous).
- In the first cycle after release, the block is in RUN with normal evaluation.
- Simultaneous events: the highest-priority event wins completely. Lower-priority events are not combined with it.
  - Example: branch plus load_use produces only the branch flush. The load in EX is itself younger than the branch, so it is flushed.
- Register r0 never causes a load-use stall.

## Structure
- Shared package `lapido_defs.v` gains `HZ_STATE_W`=2 and localparams `HZ_RUN`=0, `HZ_MEM_WAIT`=1, `HZ_RECOVER`=2.
- One sub-module is natural: `sat_counter` (parameter WIDTH; ports clk, rst, inc, count), instantiated twice for the performance counters.
- The FSM, wait counter and hazard compare stay in hazard_controller.

## Test plan
- ex_is_load=1, ex_wr_addr=5, id_rs=5, id_uses_rs=1 -> for one cycle: pc/if_id enables 0, flush_id_ex=1, stall_pipeline=1; stall_cycles goes 0→1.
- Same stimulus but ex_wr_addr=0 (or id_uses_rs=0) -> no stall, all enables 1.
- mem_branch_taken=1 together with a load_use match and id_is_jump=1 -> all three flushes 1, enables 1; flush_events +1.
- mem_busy held for 4 cycles -> 4 cycles with all enables 0; RUN on the 5th; stall_cycles=4; mem_timeout=0.
- mem_busy held for 20 cycles with MEM_WAIT_MAX=15 -> mem_timeout set after the 15th wait cycle; one RECOVER cycle with all flushes 1; mem_timeout stays 1 until rst=0.
- Force 2^16+3 load-use cycles, then assert rst=0 mid-MEM_WAIT -> stall_cycles saturates at 65535, then reads 0 immediately after the reset edge, with enables 0.
